// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared states and frame constants for the instruction memory loader
package instr_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - byte stream in and instruction memory write port out
interface instr_mem_loader_if #(
  parameter int ADDR_W = 32
);

  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [31:0]       mem_wd;

  // master: the loader (consumes bytes, drives the memory write port)
  modport master (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output mem_we,
    output mem_wa,
    output mem_wd
  );

  modport slave (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  mem_we,
    input  mem_wa,
    input  mem_wd
  );

endinterface

// File: rtl/instr_mem_loader_word_assembler.sv
// rtl/instr_mem_loader_word_assembler.sv - steers little-endian bytes into a 32-bit word
module loader_word_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] lane;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane <= 2'd0;
      word <= 32'd0;
    end else if (clear) begin
      lane <= 2'd0;
      word <= 32'd0;
    end else if (load) begin
      word[{lane, 3'b000} +: 8] <= data;
      lane                      <= lane + 2'd1;
    end
  end

  // High in the cycle whose accepted byte completes the word, so the FSM can move to WRITE on that edge.
  assign word_full = load && (lane == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - loads a length-prefixed byte image into instruction memory, then releases the core
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  instr_mem_loader_if.master bus,
  output logic               cpu_rst,
  output logic               done,
  output logic               err
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       n_len;
  logic [15:0]       word_idx;
  logic [ADDR_W-1:0] wa_q;
  logic [31:0]       wd_q;
  logic [31:0]       asm_word;
  logic              word_full;
  logic              ready;
  logic              accept;
  logic              start_ok;
  logic              we;
  logic [15:0]       n_full;
  logic              last_word;
  logic [ADDR_W-1:0] wr_addr;

  assign ready    = (state == ST_LEN_LO) || (state == ST_LEN_HI) || (state == ST_DATA);
  assign accept   = ready && bus.byte_valid;
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign n_full   = {bus.byte_in, n_len[7:0]};
  assign last_word = ({1'b0, word_idx} + 17'd1) == {1'b0, n_len};
  assign wr_addr  = {{(ADDR_W-18){1'b0}}, word_idx, 2'b00};

  loader_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .load      (accept && (state == ST_DATA)),
    .data      (bus.byte_in),
    .word      (asm_word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      n_len    <= 16'd0;
      word_idx <= 16'd0;
      wa_q     <= '0;
      wd_q     <= 32'd0;
    end else begin
      state <= state_nxt;
      if (start_ok) word_idx <= 16'd0;
      if (accept && (state == ST_LEN_LO)) n_len[7:0]  <= bus.byte_in;
      if (accept && (state == ST_LEN_HI)) n_len[15:8] <= bus.byte_in;
      // Capture the written address/data so the port holds them after the pulse.
      if (state == ST_WRITE) begin
        word_idx <= word_idx + 16'd1;
        wa_q     <= wr_addr;
        wd_q     <= asm_word;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    done      = 1'b0;
    cpu_rst   = 1'b0;
    err       = 1'b0;
    case (state)
      ST_IDLE:   if (start_ok) state_nxt = ST_LEN_LO;
      ST_LEN_LO: if (accept) state_nxt = ST_LEN_HI;
      ST_LEN_HI: begin
        if (accept) begin
          if ({1'b0, n_full} > DEPTH_L) state_nxt = ST_ERR;
          else if (n_full == 16'd0)     state_nxt = ST_DONE;
          else                          state_nxt = ST_DATA;
        end
      end
      ST_DATA:   if (word_full) state_nxt = ST_WRITE;
      ST_WRITE: begin
        we        = 1'b1;
        state_nxt = last_word ? ST_DONE : ST_DATA;
      end
      ST_DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b1;
        if (start_ok) state_nxt = ST_LEN_LO;
      end
      ST_ERR: begin
        err = 1'b1;
        if (start_ok) state_nxt = ST_LEN_LO;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign bus.byte_ready = ready;
  assign bus.mem_we     = we;
  assign bus.mem_wa     = we ? wr_addr : wa_q;
  assign bus.mem_wd     = we ? asm_word : wd_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;

  typedef logic [7:0] bq_t[$];

  logic clk;
  logic rst;
  logic start;
  logic cpu_rst;
  logic done;
  logic err;

  instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [31:0] log_wa[$];
  logic [31:0] log_wd[$];
  int          exp_n;
  int          wr_count;
  bit          expect_done;
  bit          done_next;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: every write pulse must match the next write the model predicts.
  always @(negedge clk) begin
    if (rst) begin
      if (done_next) begin
        chk("done_cpu_rst_after_last_write", 32'({done, cpu_rst}), 32'h3);
        done_next = 1'b0;
      end
      if (bus.mem_we) begin
        wr_count++;
        log_wa.push_back(bus.mem_wa);
        log_wd.push_back(bus.mem_wd);
        chk("ready_low_during_write", 32'(bus.byte_ready), 32'h0);
        if (exp_wa.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got wa=0x%0h wd=0x%0h expected no write", bus.mem_wa, bus.mem_wd);
        end else begin
          chk("write_addr", bus.mem_wa, exp_wa.pop_front());
          chk("write_data", bus.mem_wd, exp_wd.pop_front());
          if (exp_wa.size() == 0 && expect_done) done_next = 1'b1;
        end
      end
    end
  end

  // Model: decode the frame straight from the byte list.
  task automatic model_frame(input bq_t b);
    int n;
    n = int'({b[1], b[0]});
    exp_wa.delete();
    exp_wd.delete();
    log_wa.delete();
    log_wd.delete();
    wr_count    = 0;
    done_next   = 1'b0;
    expect_done = (n > 0) && (n <= DEPTH);
    exp_n       = (n <= DEPTH) ? n : 0;
    for (int i = 0; i < exp_n; i++) begin
      exp_wa.push_back(32'(i * 4));
      exp_wd.push_back({b[2+4*i+3], b[2+4*i+2], b[2+4*i+1], b[2+4*i]});
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bytes(input bq_t b, input int count, input bit gaps);
    int t;
    int g;
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        g = int'($urandom_range(0, 3));
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'($urandom);
        repeat (g) @(negedge clk);
      end
      bus.byte_in    = b[i];
      bus.byte_valid = 1'b1;
      t = 0;
      while (!bus.byte_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) begin
        checks++;
        failures++;
        $display("FAIL byte_accept_timeout: byte %0d not accepted within 50 cycles", i);
      end
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag, input bit exp_err);
    int t;
    t = 0;
    while (!(done || err) && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'(!exp_err));
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_err));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_write_count"}, 32'(wr_count), 32'(exp_n));
    chk({tag, "_pending_writes"}, 32'(exp_wa.size()), 32'h0);
  endtask

  task automatic pin_two_word(input string tag);
    chk({tag, "_wa0"}, (log_wa.size() > 0) ? log_wa[0] : 32'hDEAD_BEEF, 32'h0);
    chk({tag, "_wd0"}, (log_wd.size() > 0) ? log_wd[0] : 32'hDEAD_BEEF, 32'h0062_E233);
    chk({tag, "_wa1"}, (log_wa.size() > 1) ? log_wa[1] : 32'hDEAD_BEEF, 32'h4);
    chk({tag, "_wd1"}, (log_wd.size() > 1) ? log_wd[1] : 32'hDEAD_BEEF, 32'h00B6_2423);
    chk({tag, "_pulses"}, 32'(wr_count), 32'd2);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'h0);
    chk({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'h0);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  initial begin
    bq_t two_word;
    bq_t one_word;
    bq_t zero_len;
    bq_t too_long;
    two_word = '{8'h02, 8'h00, 8'h33, 8'hE2, 8'h62, 8'h00, 8'h23, 8'h24, 8'hB6, 8'h00};
    one_word = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    zero_len = '{8'h00, 8'h00};
    too_long = '{8'h01, 8'h04};

    rst            = 1'b0;
    start          = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'hFF;
    exp_n          = 0;
    wr_count       = 0;
    expect_done    = 1'b0;
    done_next      = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    bus.byte_valid = 1'b0;
    rst            = 1'b1;

    // Two-word image with valid held high.
    do_start();
    model_frame(two_word);
    send_bytes(two_word, two_word.size(), 1'b0);
    wait_end("two_word", 1'b0);
    pin_two_word("two_word");

    // Reload from DONE with a one-word image.
    do_start();
    chk("reload_done_drop", 32'(done), 32'h0);
    chk("reload_cpu_rst_drop", 32'(cpu_rst), 32'h0);
    model_frame(one_word);
    send_bytes(one_word, one_word.size(), 1'b0);
    wait_end("one_word", 1'b0);
    chk("one_word_wa", (log_wa.size() > 0) ? log_wa[0] : 32'hDEAD_BEEF, 32'h0);
    chk("one_word_wd", (log_wd.size() > 0) ? log_wd[0] : 32'hDEAD_BEEF, 32'h0000_0013);

    // Same two-word image with random gaps in byte_valid.
    for (int rep = 0; rep < 3; rep++) begin
      do_start();
      model_frame(two_word);
      send_bytes(two_word, two_word.size(), 1'b1);
      wait_end("gaps", 1'b0);
      pin_two_word("gaps");
    end

    // Zero-length image.
    do_start();
    model_frame(zero_len);
    send_bytes(zero_len, zero_len.size(), 1'b0);
    wait_end("zero_len", 1'b0);

    // Oversize length, then start clears err.
    do_start();
    model_frame(too_long);
    send_bytes(too_long, too_long.size(), 1'b0);
    wait_end("oversize", 1'b1);
    repeat (3) @(negedge clk);
    chk("oversize_err_sticky", 32'(err), 32'h1);
    do_start();
    chk("err_cleared_by_start", 32'(err), 32'h0);
    model_frame(zero_len);
    send_bytes(zero_len, zero_len.size(), 1'b0);
    wait_end("after_err", 1'b0);

    // Abort mid-load after the 6th byte, then a clean reload.
    do_start();
    model_frame(two_word);
    send_bytes(two_word, 6, 1'b0);
    #1;
    rst = 1'b0;
    exp_wa.delete();
    exp_wd.delete();
    expect_done = 1'b0;
    done_next   = 1'b0;
    #1;
    chk("midload_writes_before_abort", 32'(wr_count), 32'd1);
    chk_reset_outputs("midload_reset");
    @(negedge clk);
    rst = 1'b1;
    do_start();
    model_frame(two_word);
    send_bytes(two_word, two_word.size(), 1'b0);
    wait_end("restart", 1'b0);
    pin_two_word("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
